// File: rtl/bomb_placement_controller_if.sv
// Handshake and board-output bundle for the bomb placement controller.
// The controller owns the master modport; the generator/board side uses the slave modport.
interface bomb_placement_controller_if;
    logic        start;
    logic [5:0]  num_bombs;
    logic        rnd_valid;
    logic [2:0]  rnd_row;
    logic [2:0]  rnd_col;
    logic        rnd_ready;
    logic        place_we;
    logic [2:0]  place_row;
    logic [2:0]  place_col;
    logic        cnt_we;
    logic [2:0]  cnt_row;
    logic [2:0]  cnt_col;
    logic [3:0]  cnt_value;
    logic        cnt_is_bomb;
    logic [63:0] bomb_map;
    logic [5:0]  bombs_placed;
    logic        busy;
    logic        done;

    modport master (
        input  start, num_bombs, rnd_valid, rnd_row, rnd_col,
        output rnd_ready, place_we, place_row, place_col,
        output cnt_we, cnt_row, cnt_col, cnt_value, cnt_is_bomb,
        output bomb_map, bombs_placed, busy, done
    );

    modport slave (
        output start, num_bombs, rnd_valid, rnd_row, rnd_col,
        input  rnd_ready, place_we, place_row, place_col,
        input  cnt_we, cnt_row, cnt_col, cnt_value, cnt_is_bomb,
        input  bomb_map, bombs_placed, busy, done
    );
endinterface

// File: rtl/bomb_placement_controller.sv
// Builds an 8x8 minesweeper board: places distinct random bombs, then streams
// every cell's adjacent-bomb count in row-major order.
module bomb_placement_controller #(
    parameter int unsigned MAX_BOMBS = 20
) (
    input logic                          clk,
    input logic                          reset,
    bomb_placement_controller_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StPlace, StCount, StFinish} state_e;

    localparam logic [5:0] MaxBombsW = 6'(MAX_BOMBS);

    state_e     state_q;
    logic [5:0] target_q;
    logic [5:0] scan_q;

    logic [5:0] start_target;
    logic [5:0] rnd_idx;
    logic [3:0] scan_count;

    // Off-grid neighbours are skipped, so edges and corners never wrap.
    function automatic logic [3:0] nbr_count(input logic [63:0] map, input logic [5:0] idx);
        logic [3:0] sum;
        int         r;
        int         c;
        sum = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(idx[5:3]) + dr;
                c = int'(idx[2:0]) + dc;
                if ((dr != 0 || dc != 0) && r >= 0 && r < 8 && c >= 0 && c < 8) begin
                    sum = sum + 4'(map[6'(r * 8 + c)]);
                end
            end
        end
        return sum;
    endfunction

    always_comb begin
        start_target = (bus.num_bombs > MaxBombsW) ? MaxBombsW : bus.num_bombs;
        rnd_idx      = {bus.rnd_row, bus.rnd_col};
        scan_count   = nbr_count(bus.bomb_map, scan_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            target_q         <= '0;
            scan_q           <= '0;
            bus.rnd_ready    <= 1'b0;
            bus.place_we     <= 1'b0;
            bus.place_row    <= '0;
            bus.place_col    <= '0;
            bus.cnt_we       <= 1'b0;
            bus.cnt_row      <= '0;
            bus.cnt_col      <= '0;
            bus.cnt_value    <= '0;
            bus.cnt_is_bomb  <= 1'b0;
            bus.bomb_map     <= '0;
            bus.bombs_placed <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.place_we <= 1'b0;
            bus.done     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        target_q         <= start_target;
                        scan_q           <= '0;
                        bus.bomb_map     <= '0;
                        bus.bombs_placed <= '0;
                        bus.busy         <= 1'b1;
                        if (start_target == 6'd0) begin
                            state_q <= StCount;
                        end else begin
                            state_q       <= StPlace;
                            bus.rnd_ready <= 1'b1;
                        end
                    end
                end
                StPlace: begin
                    if (bus.rnd_valid && bus.rnd_ready && !bus.bomb_map[rnd_idx]) begin
                        bus.bomb_map[rnd_idx] <= 1'b1;
                        bus.place_we          <= 1'b1;
                        bus.place_row         <= bus.rnd_row;
                        bus.place_col         <= bus.rnd_col;
                        bus.bombs_placed      <= bus.bombs_placed + 6'd1;
                        if (bus.bombs_placed + 6'd1 == target_q) begin
                            bus.rnd_ready <= 1'b0;
                            state_q       <= StCount;
                        end
                    end
                end
                StCount: begin
                    // Leave only after cell (7,7) has been presented for one cycle.
                    if (bus.cnt_we && {bus.cnt_row, bus.cnt_col} == 6'd63) begin
                        bus.cnt_we <= 1'b0;
                        bus.done   <= 1'b1;
                        state_q    <= StFinish;
                    end else begin
                        bus.cnt_we      <= 1'b1;
                        bus.cnt_row     <= scan_q[5:3];
                        bus.cnt_col     <= scan_q[2:0];
                        bus.cnt_value   <= scan_count;
                        bus.cnt_is_bomb <= bus.bomb_map[scan_q];
                        scan_q          <= scan_q + 6'd1;
                    end
                end
                StFinish: begin
                    bus.busy <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_placement_controller.sv
// Directed and random boards checked against a grid-level reference model.
module tb_bomb_placement_controller;

    localparam int MaxBombs = 20;

    logic clk = 1'b0;
    logic reset;

    bomb_placement_controller_if bus ();

    bomb_placement_controller #(
        .MAX_BOMBS(MaxBombs)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Output monitor, sampled on the falling edge.
    int         place_cnt;
    int         cnt_cycles;
    int         done_cnt;
    int         rdy_cnt;
    logic [5:0] place_log[$];
    logic [5:0] cnt_idx[64];
    logic [3:0] cnt_val[64];
    logic       cnt_bomb[64];

    always @(negedge clk) begin
        if (bus.place_we) begin
            place_cnt++;
            place_log.push_back({bus.place_row, bus.place_col});
        end
        if (bus.cnt_we) begin
            if (cnt_cycles < 64) begin
                cnt_idx[cnt_cycles]  = {bus.cnt_row, bus.cnt_col};
                cnt_val[cnt_cycles]  = bus.cnt_value;
                cnt_bomb[cnt_cycles] = bus.cnt_is_bomb;
            end
            cnt_cycles++;
        end
        if (bus.done) done_cnt++;
        if (bus.rnd_ready) rdy_cnt++;
    end

    // Reference model: the board as a plain grid plus the placement order.
    bit         mdl_map[8][8];
    int         mdl_placed;
    int         mdl_target;
    int         feeds;
    logic [5:0] mdl_log[$];
    logic [5:0] dir_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mdl_packed();
        logic [63:0] m;
        m = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) m[6'(r * 8 + c)] = mdl_map[r][c];
        return m;
    endfunction

    // Sum of the 3x3 window on a zero-padded 10x10 grid, minus the centre.
    function automatic int ref_count(input int r, input int c);
        bit pad[10][10];
        int sum;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++) pad[i][j] = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) pad[i + 1][j + 1] = mdl_map[i][j];
        sum = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) sum += int'(pad[r + i][c + j]);
        return sum - int'(pad[r + 1][c + 1]);
    endfunction

    task automatic clear_mon();
        place_cnt  = 0;
        cnt_cycles = 0;
        done_cnt   = 0;
        rdy_cnt    = 0;
        place_log.delete();
    endtask

    task automatic start_and_place(input int n, input bit mid_start);
        logic [5:0] p;
        clear_mon();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mdl_map[r][c] = 1'b0;
        mdl_placed = 0;
        mdl_log.delete();
        mdl_target = (n > MaxBombs) ? MaxBombs : n;
        feeds      = 0;
        bus.num_bombs = 6'(n);
        bus.start     = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.rnd_row   = 3'($urandom);
        bus.rnd_col   = 3'($urandom);
        tick();
        bus.start     = 1'b0;
        bus.num_bombs = 6'($urandom);
        chk("busy_after_start", 64'(bus.busy), 64'(1));
        chk("ready_after_start", 64'(bus.rnd_ready), 64'(mdl_target != 0));
        while (mdl_placed < mdl_target && feeds < 3000) begin
            if (dir_q.size() > 0) p = dir_q.pop_front();
            else p = 6'($urandom);
            bus.rnd_valid = 1'b1;
            bus.rnd_row   = p[5:3];
            bus.rnd_col   = p[2:0];
            if (mid_start && feeds == 4) begin
                bus.start     = 1'b1;
                bus.num_bombs = 6'd5;
            end
            tick();
            feeds++;
            bus.start = 1'b0;
            if (!mdl_map[p[5:3]][p[2:0]]) begin
                mdl_map[p[5:3]][p[2:0]] = 1'b1;
                mdl_placed++;
                mdl_log.push_back(p);
            end
        end
        chk("place_bounded", 64'(feeds < 3000), 64'(1));
        chk("ready_dropped", 64'(bus.rnd_ready), 64'(0));
    endtask

    task automatic finish_board(input string tag);
        int k;
        k = 0;
        // Keep strobing coordinates: they must be ignored outside PLACE.
        while (done_cnt == 0 && k < 200) begin
            bus.rnd_valid = 1'b1;
            bus.rnd_row   = 3'($urandom);
            bus.rnd_col   = 3'($urandom);
            tick();
            k++;
        end
        bus.rnd_valid = 1'b0;
        chk({tag, "_done_once"}, 64'(done_cnt), 64'(1));
        chk({tag, "_busy_low"}, 64'(bus.busy), 64'(0));
        chk({tag, "_done_low"}, 64'(bus.done), 64'(0));
        chk({tag, "_cnt_cycles"}, 64'(cnt_cycles), 64'(64));
        chk({tag, "_place_cnt"}, 64'(place_cnt), 64'(mdl_target));
        chk({tag, "_bombs_placed"}, 64'(bus.bombs_placed), 64'(mdl_target));
        chk({tag, "_bomb_map"}, bus.bomb_map, mdl_packed());
        chk({tag, "_ready_cycles"}, 64'(rdy_cnt), 64'(feeds));
        if (place_log.size() == mdl_log.size()) begin
            for (int i = 0; i < mdl_log.size(); i++)
                chk({tag, "_place_coord"}, 64'(place_log[i]), 64'(mdl_log[i]));
        end
        if (cnt_cycles == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk({tag, "_cell_order"}, 64'(cnt_idx[i]), 64'(i));
                chk({tag, "_cell_value"}, 64'(cnt_val[i]), 64'(ref_count(i / 8, i % 8)));
                chk({tag, "_cell_bomb"}, 64'(cnt_bomb[i]), 64'(mdl_map[i / 8][i % 8]));
            end
        end
        tick();
        tick();
        chk({tag, "_no_extra_done"}, 64'(done_cnt), 64'(1));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_map"}, bus.bomb_map, 64'(0));
        chk({tag, "_placed"}, 64'(bus.bombs_placed), 64'(0));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_ready"}, 64'(bus.rnd_ready), 64'(0));
        chk({tag, "_cnt_we"}, 64'(bus.cnt_we), 64'(0));
        chk({tag, "_place_we"}, 64'(bus.place_we), 64'(0));
        chk({tag, "_cnt_fields"},
            64'({bus.cnt_row, bus.cnt_col, bus.cnt_value, bus.cnt_is_bomb}), 64'(0));
        chk({tag, "_place_fields"}, 64'({bus.place_row, bus.place_col}), 64'(0));
    endtask

    initial begin
        int k;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.num_bombs = '0;
        bus.rnd_valid = 1'b0;
        bus.rnd_row   = '0;
        bus.rnd_col   = '0;
        clear_mon();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_idle_zero("reset");

        // Duplicate (2,3) must be discarded.
        dir_q = '{6'd19, 6'd19, 6'd41, 6'd0};
        start_and_place(3, 1'b0);
        finish_board("dup");
        chk("dup_map_bits", bus.bomb_map, 64'h0000_0200_0008_0001);

        dir_q = '{6'd0, 6'd1, 6'd8};
        start_and_place(3, 1'b0);
        finish_board("corner");
        chk("corner_1_1", 64'(cnt_val[9]), 64'(3));
        chk("corner_0_0", 64'(cnt_val[0]), 64'(2));
        chk("corner_0_0_bomb", 64'(cnt_bomb[0]), 64'(1));
        chk("corner_7_7", 64'(cnt_val[63]), 64'(0));

        dir_q = '{6'd27, 6'd28, 6'd29, 6'd35, 6'd37, 6'd43, 6'd44, 6'd45};
        start_and_place(8, 1'b0);
        finish_board("ring");
        chk("ring_4_4", 64'(cnt_val[36]), 64'(8));

        dir_q = '{6'd54, 6'd55, 6'd62};
        start_and_place(3, 1'b0);
        finish_board("far");
        chk("far_7_7", 64'(cnt_val[63]), 64'(3));

        start_and_place(0, 1'b0);
        finish_board("zero");
        chk("zero_no_ready", 64'(rdy_cnt), 64'(0));

        // Clamped request with a start pulse mid-placement that must be ignored.
        start_and_place(40, 1'b1);
        finish_board("clamp");
        chk("clamp_placed", 64'(bus.bombs_placed), 64'(20));
        chk("clamp_pulses", 64'(place_cnt), 64'(20));

        // Reset while cell (3,5) is on the count outputs.
        start_and_place(12, 1'b0);
        k = 0;
        while (!(bus.cnt_we && bus.cnt_row == 3'd3 && bus.cnt_col == 3'd5) && k < 200) begin
            tick();
            k++;
        end
        chk("reach_cell_3_5", 64'({bus.cnt_we, bus.cnt_row, bus.cnt_col}), 64'({1'b1, 6'd29}));
        reset = 1'b1;
        #1;
        chk_idle_zero("mid_reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("mid_reset_no_done", 64'(done_cnt), 64'(0));
        chk_idle_zero("after_reset");

        for (int b = 0; b < 3; b++) begin
            start_and_place(int'($urandom_range(1, 30)), 1'b0);
            finish_board("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bomb_placement_controller.md
Name: bomb_placement_controller

Overview:
- Sequences the random coordinate generator to build a minesweeper board on an 8x8 grid.
- On start, clears the board and accepts random (row, column) pairs until the requested number of distinct bombs is placed; duplicate coordinates are discarded.
- Then scans all 64 cells in row-major order and emits each cell's adjacent-bomb count to the board memory.
- Sits between the random coordinate generator and the board RAM/display logic.

Parameters:
- MAX_BOMBS, 20, upper limit on bombs per board; a larger request is clamped to this value (must be 1..63).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to generate a new board; ignored unless in IDLE
- num_bombs  input  6  requested bomb count, sampled on accepted start
- rnd_valid  input  1  new random coordinate available (generator update strobe)
- rnd_row  input  3  random row
- rnd_col  input  3  random column
- rnd_ready  output  1  high only in PLACE; a coordinate is accepted when rnd_valid && rnd_ready
- place_we  output  1  one-cycle pulse per newly placed bomb
- place_row  output  3  row of placed bomb
- place_col  output  3  column of placed bomb
- cnt_we  output  1  count-write strobe, high during COUNT output cycles
- cnt_row  output  3  cell row of the current count
- cnt_col  output  3  cell column of the current count
- cnt_value  output  4  adjacent-bomb count, 0..8
- cnt_is_bomb  output  1  current cell holds a bomb
- bomb_map  output  64  occupancy map, bit index = row*8+col
- bombs_placed  output  6  distinct bombs placed so far
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when the board is complete

Behaviour:
- Reset: state IDLE; all outputs 0, including bomb_map, bombs_placed, all strobes, cnt_* and place_* fields; internal target and scan index are cleared.
- States: IDLE, PLACE, COUNT, FINISH.
- IDLE, start=1 (cycle 0):
  - target := min(num_bombs, MAX_BOMBS).
  - bomb_map and bombs_placed are cleared.
  - Next state is PLACE, or COUNT if target==0.
  - busy goes high in cycle 1.
- PLACE: rnd_ready=1.
  - Accepted coordinate with bomb_map[r*8+c]==0: the bit is set; place_we=1 with place_row=r and place_col=c in the next cycle; bombs_placed increments.
  - Accepted coordinate with the bit already set: discarded, no place_we, no count change.
  - When the acceptance makes bombs_placed reach target, rnd_ready drops in the next cycle and the state moves to COUNT.
  - rnd_valid while not in PLACE is ignored.
- COUNT: 64 consecutive cycles with cnt_we=1, cells in row-major order (0,0), (0,1) .. (7,7).
  - cnt_value is the number of set bits among the 8 neighbours; off-grid neighbours are not counted, with no wrap-around.
  - cnt_is_bomb is the cell's own bit. A bomb cell still reports its neighbour count.
  - All cnt_* outputs are registered and valid in the same cycle as cnt_we.
  - The cycle after cell (7,7), cnt_we=0 and the state moves to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. busy is low in the cycle after done.
- After completion: bomb_map and bombs_placed hold until the next accepted start or reset.
- start while busy: ignored; target is not resampled.
- Reset mid-operation (any state): immediate return to IDLE with the reset values above; no done pulse.
- Width rules:
  - bombs_placed never exceeds target.
  - cnt_value maximum is 8 (4 bits).
  - Neighbour indexing must guard against row/col 0 and 7 underflow or overflow.

Test Plan:
- Reset, then start with num_bombs=3; feed (2,3), (2,3), (5,1), (0,0) -> place_we exactly 3 times; duplicate (2,3) ignored; bombs_placed=3; bomb_map bits 19, 41 and 0 set.
- Bombs at (0,0), (0,1), (1,0) -> COUNT reports (1,1)=3, (0,0)=2 with cnt_is_bomb=1, (7,7)=0; exactly 64 cnt_we cycles, then one done pulse.
- Bombs surrounding (4,4) on all 8 neighbours -> cnt_value for (4,4)=8; corner (7,7) with bombs at (6,6), (6,7), (7,6) -> 3.
- num_bombs=0 -> PLACE skipped, rnd_ready never high, 64 counts of 0, done.
- num_bombs=40 -> clamped, bombs_placed=20 and 20 place_we pulses; start pulsed mid-PLACE -> ignored, count unchanged.
- Reset asserted during COUNT at cell (3,5) -> outputs 0 immediately, no done; a new start then completes a normal sequence.
